// File: rtl/cla_16.sv
// Registered 16-bit two-level carry-lookahead adder, bit 1 = MSB on all buses.
// Define CLA_COUT_EN to expose the registered carry-out on port co.
module cla_16 (
    input  logic clk,
    input  logic rst_n,
    input  logic a1,  input logic a2,  input logic a3,  input logic a4,
    input  logic a5,  input logic a6,  input logic a7,  input logic a8,
    input  logic a9,  input logic a10, input logic a11, input logic a12,
    input  logic a13, input logic a14, input logic a15, input logic a16,
    input  logic b1,  input logic b2,  input logic b3,  input logic b4,
    input  logic b5,  input logic b6,  input logic b7,  input logic b8,
    input  logic b9,  input logic b10, input logic b11, input logic b12,
    input  logic b13, input logic b14, input logic b15, input logic b16,
    output logic o1,  output logic o2,  output logic o3,  output logic o4,
    output logic o5,  output logic o6,  output logic o7,  output logic o8,
    output logic o9,  output logic o10, output logic o11, output logic o12,
`ifdef CLA_COUT_EN
    output logic o13, output logic o14, output logic o15, output logic o16,
    output logic co
`else
    output logic o13, output logic o14, output logic o15, output logic o16
`endif
);

    logic [15:0] a, b, g, p;
    logic [15:0] sum_d, sum_q;
    logic [16:0] c;
    logic [3:0]  gg, gp;
    logic [4:0]  gc;
    logic        cin;

    assign cin = 1'b0;
    assign a = {a1, a2, a3, a4, a5, a6, a7, a8,
                a9, a10, a11, a12, a13, a14, a15, a16};
    assign b = {b1, b2, b3, b4, b5, b6, b7, b8,
                b9, b10, b11, b12, b13, b14, b15, b16};
    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        gg = '0;
        gp = '0;
        for (int k = 0; k < 4; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
    end

    // Group carries are flattened sums of products, no inter-group ripple.
    assign gc[0] = cin;
    assign gc[1] = gg[0] | (gp[0] & cin);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & cin);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

    always_comb begin
        c = '0;
        c[16] = gc[4];
        for (int k = 0; k < 4; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
    end

    assign sum_d = p ^ c[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    assign {o1, o2, o3, o4, o5, o6, o7, o8,
            o9, o10, o11, o12, o13, o14, o15, o16} = sum_q;

`ifdef CLA_COUT_EN
    logic co_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) co_q <= 1'b0;
        else        co_q <= c[16];
    end
    assign co = co_q;
`endif

endmodule

// File: tb/tb_cla_16.sv
// Directed bench for cla_16: reset, latency, group-boundary carries,
// plus a short random sweep against an (A+B) model.
module tb_cla_16;

    logic clk, rst_n;
    logic a1, a2, a3, a4, a5, a6, a7, a8;
    logic a9, a10, a11, a12, a13, a14, a15, a16;
    logic b1, b2, b3, b4, b5, b6, b7, b8;
    logic b9, b10, b11, b12, b13, b14, b15, b16;
    logic o1, o2, o3, o4, o5, o6, o7, o8;
    logic o9, o10, o11, o12, o13, o14, o15, o16;
    logic co;
    logic [15:0] o_w;
    int n_vec, n_miss;

    cla_16 dut (
        .clk(clk), .rst_n(rst_n),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4),
        .a5(a5), .a6(a6), .a7(a7), .a8(a8),
        .a9(a9), .a10(a10), .a11(a11), .a12(a12),
        .a13(a13), .a14(a14), .a15(a15), .a16(a16),
        .b1(b1), .b2(b2), .b3(b3), .b4(b4),
        .b5(b5), .b6(b6), .b7(b7), .b8(b8),
        .b9(b9), .b10(b10), .b11(b11), .b12(b12),
        .b13(b13), .b14(b14), .b15(b15), .b16(b16),
        .o1(o1), .o2(o2), .o3(o3), .o4(o4),
        .o5(o5), .o6(o6), .o7(o7), .o8(o8),
        .o9(o9), .o10(o10), .o11(o11), .o12(o12),
`ifdef CLA_COUT_EN
        .o13(o13), .o14(o14), .o15(o15), .o16(o16),
        .co(co)
`else
        .o13(o13), .o14(o14), .o15(o15), .o16(o16)
`endif
    );

`ifndef CLA_COUT_EN
    assign co = 1'b0;
`endif

    assign o_w = {o1, o2, o3, o4, o5, o6, o7, o8,
                  o9, o10, o11, o12, o13, o14, o15, o16};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [15:0] av, input logic [15:0] bv);
        {a1, a2, a3, a4, a5, a6, a7, a8,
         a9, a10, a11, a12, a13, a14, a15, a16} = av;
        {b1, b2, b3, b4, b5, b6, b7, b8,
         b9, b10, b11, b12, b13, b14, b15, b16} = bv;
    endtask

    task automatic check(input string tag, input logic [15:0] exp_s,
                         input logic exp_c);
        n_vec++;
        assert (o_w === exp_s) else begin
            n_miss++;
            $error("FAIL %s: sum=%h expected %h", tag, o_w, exp_s);
        end
`ifdef CLA_COUT_EN
        assert (co === exp_c) else begin
            n_miss++;
            $error("FAIL %s.co: co=%b expected %b", tag, co, exp_c);
        end
`else
        if (exp_c === 1'bx) $display("unused carry %b", exp_c);
`endif
    endtask

    task automatic apply(input string tag, input logic [15:0] av,
                         input logic [15:0] bv, input logic [15:0] es,
                         input logic ec);
        @(negedge clk);
        drive(av, bv);
        @(posedge clk);
        #1;
        check(tag, es, ec);
    endtask

    initial begin
        logic [16:0] model;
        logic [15:0] ra, rb;
        n_vec = 0;
        n_miss = 0;
        rst_n = 1'b0;
        drive(16'h1234, 16'h1111);
        #3;
        check("reset_init", 16'h0000, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 16'h0000, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        apply("basic_add", 16'h007B, 16'h0064, 16'h00DF, 1'b0);

        // Output must not follow inputs between edges.
        @(negedge clk);
        drive(16'h1000, 16'h0234);
        #2;
        check("latency_hold", 16'h00DF, 1'b0);
        @(posedge clk);
        #1;
        check("latency_load", 16'h1234, 1'b0);

        apply("reload", 16'h007B, 16'h0064, 16'h00DF, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid", 16'h0000, 1'b0);
        drive(16'h0FFF, 16'h0001);
        @(posedge clk);
        #1;
        check("reset_mid_hold", 16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 16'h1000, 1'b0);

        apply("prop_chain", 16'h5555, 16'hAAAA, 16'hFFFF, 1'b0);
        apply("wrap_all",   16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        apply("grp0_carry", 16'h000F, 16'h0001, 16'h0010, 1'b0);
        apply("grp2_carry", 16'h0FFF, 16'h0001, 16'h1000, 1'b0);
        apply("msb_carry",  16'h8000, 16'h8000, 16'h0000, 1'b1);
        apply("grp1_carry", 16'h00FF, 16'h0001, 16'h0100, 1'b0);
        apply("all_ones",   16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1);
        apply("no_carry",   16'h1234, 16'h4321, 16'h5555, 1'b0);
        apply("into_msb",   16'h7FFF, 16'h0001, 16'h8000, 1'b0);
        apply("mid_nibble", 16'h00F0, 16'h0010, 16'h0100, 1'b0);
        apply("top_grp",    16'hF000, 16'h1000, 16'h0000, 1'b1);
        apply("mixed",      16'hABCD, 16'h1234, 16'hBE01, 1'b0);
        apply("sparse",     16'h8421, 16'h0842, 16'h8C63, 1'b0);
        apply("exact_wrap", 16'hC350, 16'h3CB0, 16'h0000, 1'b1);
        apply("zero",       16'h0000, 16'h0000, 16'h0000, 1'b0);

        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            model = {1'b0, ra} + {1'b0, rb};
            apply("random", ra, rb, model[15:0], model[16]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
